// File: rtl/cpu_reg_dump_tx.sv
// cpu_reg_dump_tx: snapshots the CPU register bus and sends it as a UART 8N1 frame.
// Optional checksum byte: define DUMP_CHECKSUM_EN.
module cpu_reg_dump_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig,
    input  logic [15:0] r_PC,
    input  logic [7:0]  r_AC,
    input  logic [7:0]  r_SP,
    input  logic [7:0]  r_XR,
    input  logic [7:0]  r_YR,
    input  logic [7:0]  r_SR,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic        dropped
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

`ifdef DUMP_CHECKSUM_EN
    localparam logic [3:0] LAST = 4'd8;
`else
    localparam logic [3:0] LAST = 4'd7;
`endif
    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [3:0]  byte_q, byte_d;
    logic [55:0] shadow_q, shadow_d;
    logic [55:0] pshadow_q, pshadow_d;
    logic        pend_q, pend_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dropped_q, dropped_d;

    logic [55:0] snap;
    logic [7:0]  cur_byte;
    logic [2:0]  bit_nx;
    logic        baud_end;
    logic        frame_end;

    assign snap      = {r_PC, r_AC, r_SP, r_XR, r_YR, r_SR};
    assign bit_nx    = bit_q + 3'd1;
    assign baud_end  = (baud_q == BAUD_MAX);
    assign frame_end = (state_q == S_STOP) && baud_end && (byte_q == LAST);

`ifdef DUMP_CHECKSUM_EN
    logic [7:0] chk;
    assign chk = shadow_q[55:48] ^ shadow_q[47:40] ^ shadow_q[39:32] ^
                 shadow_q[31:24] ^ shadow_q[23:16] ^ shadow_q[15:8] ^
                 shadow_q[7:0];
`endif

    // Select the frame byte currently being shifted out.
    always_comb begin
        cur_byte = SYNC_BYTE;
        case (byte_q)
            4'd1:    cur_byte = shadow_q[55:48];
            4'd2:    cur_byte = shadow_q[47:40];
            4'd3:    cur_byte = shadow_q[39:32];
            4'd4:    cur_byte = shadow_q[31:24];
            4'd5:    cur_byte = shadow_q[23:16];
            4'd6:    cur_byte = shadow_q[15:8];
            4'd7:    cur_byte = shadow_q[7:0];
`ifdef DUMP_CHECKSUM_EN
            4'd8:    cur_byte = chk;
`endif
            default: cur_byte = SYNC_BYTE;
        endcase
    end

    // Next-state, serialiser and trigger arbitration.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        shadow_d  = shadow_q;
        pshadow_d = pshadow_q;
        pend_d    = pend_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dropped_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    shadow_d = snap;
                    state_d  = S_START;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                    baud_d   = 16'd0;
                    bit_d    = 3'd0;
                    byte_d   = 4'd0;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                    tx_d    = cur_byte[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_nx;
                        tx_d  = cur_byte[bit_nx];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d = 16'd0;
                    if (byte_q != LAST) begin
                        byte_d  = byte_q + 4'd1;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        done_d = 1'b1;
                        byte_d = 4'd0;
                        if (pend_q) begin
                            shadow_d = pshadow_q;
                            pend_d   = 1'b0;
                            state_d  = S_START;
                            tx_d     = 1'b0;
                        end else if (trig) begin
                            shadow_d = snap;
                            state_d  = S_START;
                            tx_d     = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A trigger on the final stop edge with an empty queue was
        // already taken as the next frame above.
        if (trig && state_q != S_IDLE) begin
            if (frame_end) begin
                if (pend_q) begin
                    pend_d    = 1'b1;
                    pshadow_d = snap;
                end
            end else if (!pend_q) begin
                pend_d    = 1'b1;
                pshadow_d = snap;
            end else begin
                dropped_d = 1'b1;
            end
        end
    end

    // State register; reset aborts any frame and forces the line idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= 16'd0;
            bit_q     <= 3'd0;
            byte_q    <= 4'd0;
            shadow_q  <= 56'd0;
            pshadow_q <= 56'd0;
            pend_q    <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            shadow_q  <= shadow_d;
            pshadow_q <= pshadow_d;
            pend_q    <= pend_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dropped_q <= dropped_d;
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign dropped = dropped_q;

endmodule

// File: tb/tb_cpu_reg_dump_tx.sv
// tb_cpu_reg_dump_tx: scoreboard bench with a UART receiver monitor
// and a frame-scheduling reference model.
module tb_cpu_reg_dump_tx;

    localparam int CPB = 4;
`ifdef DUMP_CHECKSUM_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int FL = NB * 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trig = 1'b0;
    logic [15:0] r_PC = 16'd0;
    logic [7:0]  r_AC = 8'd0;
    logic [7:0]  r_SP = 8'd0;
    logic [7:0]  r_XR = 8'd0;
    logic [7:0]  r_YR = 8'd0;
    logic [7:0]  r_SR = 8'd0;
    logic        tx;
    logic        busy;
    logic        done;
    logic        dropped;

    cpu_reg_dump_tx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .trig   (trig),
        .r_PC   (r_PC),
        .r_AC   (r_AC),
        .r_SP   (r_SP),
        .r_XR   (r_XR),
        .r_YR   (r_YR),
        .r_SR   (r_SR),
        .tx     (tx),
        .busy   (busy),
        .done   (done),
        .dropped(dropped)
    );

    typedef struct {
        logic [7:0] b;
        int         s;
    } exp_t;

    exp_t expq[$];
    int   doneq[$];
    int   dropq[$];
    int   ends[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference model: a trigger at edge t starts a frame if nothing is
    // scheduled past t, queues one if only the current frame remains,
    // otherwise it is discarded.
    function automatic void model_trig(input int t, input logic [55:0] v);
        int start;
        logic [7:0] b;
        logic [7:0] x;
        while (ends.size() > 0 && ends[0] <= t) void'(ends.pop_front());
        if (ends.size() >= 2) begin
            dropq.push_back(t);
            return;
        end
        start = (ends.size() == 0) ? t : ends[ends.size() - 1];
        ends.push_back(start + FL);
        doneq.push_back(start + FL);
        x = 8'h00;
        for (int k = 0; k < NB; k++) begin
            if (k == 0) b = 8'hA5;
            else if (k <= 7) b = 8'(v >> (8 * (7 - k)));
            else b = x;
            if (k >= 1 && k <= 7) x = x ^ b;
            expq.push_back('{b: b, s: start + k * 10 * CPB});
        end
    endfunction

    task automatic fire(input logic [55:0] v);
        {r_PC, r_AC, r_SP, r_XR, r_YR, r_SR} = v;
        trig = 1'b1;
        model_trig(cyc + 1, v);
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc + 1 < target) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || expq.size() != 0) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("drain_timeout", 64'(n >= 6000), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_tx", 64'(tx), 64'd1);
    endtask

    function automatic logic [55:0] rnd56();
        return {24'($urandom), 32'($urandom)};
    endfunction

    // Monitor: UART receiver plus done/dropped pulse checker.
    initial begin
        bit rx;
        int rc;
        int rs;
        logic [7:0] sh;
        exp_t e;
        int d;
        rx = 1'b0;
        rc = 0;
        rs = 0;
        sh = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                rx = 1'b0;
                continue;
            end
            if (!rx) begin
                if (tx === 1'b0) begin
                    rx = 1'b1;
                    rc = 0;
                    rs = cyc;
                end
            end else begin
                rc++;
                if (rc >= 6 && rc <= 34 && ((rc - 6) % 4) == 0)
                    sh[(rc - 6) / 4] = tx;
                if (rc == 38) begin
                    rx = 1'b0;
                    check("stop_bit", 64'(tx), 64'd1);
                    if (expq.size() == 0) begin
                        check("unexpected_byte", 64'(sh), 64'hFFFF);
                    end else begin
                        e = expq.pop_front();
                        check("byte_data", 64'(sh), 64'(e.b));
                        check("byte_start", 64'(rs), 64'(e.s));
                    end
                end
            end
            if (done === 1'b1) begin
                if (doneq.size() == 0) begin
                    check("unexpected_done", 64'(cyc), 64'hFFFF);
                end else begin
                    d = doneq.pop_front();
                    check("done_cycle", 64'(cyc), 64'(d));
                end
            end
            if (dropped === 1'b1) begin
                if (dropq.size() == 0) begin
                    check("unexpected_drop", 64'(cyc), 64'hFFFF);
                end else begin
                    d = dropq.pop_front();
                    check("drop_cycle", 64'(cyc), 64'(d));
                end
            end
        end
    end

    // Stimulus.
    initial begin
        int s0;
        bit bad;

        repeat (3) @(negedge clk);
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dropped", 64'(dropped), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Directed frame; AC is changed right after the trigger.
        fire({16'h6789, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5});
        check("start_busy", 64'(busy), 64'd1);
        check("start_tx", 64'(tx), 64'd0);
        @(negedge clk);
        r_AC = 8'h00;
        drain();

        // Three triggers inside one frame: second pends, third drops.
        s0 = cyc + 1;
        fire(rnd56());
        wait_until(s0 + 40);
        fire(rnd56());
        wait_until(s0 + 80);
        fire(rnd56());

        // Trigger on the final stop edge of the pended frame.
        wait_until(ends[ends.size() - 1]);
        fire(rnd56());
        drain();

        // Random triggers with random spacing.
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(1, 450)) @(negedge clk);
            fire(rnd56());
        end
        drain();

        // Asynchronous reset during the data bits of byte 3.
        s0 = cyc + 1;
        fire(rnd56());
        wait_until(s0 + 3 * 10 * CPB + 2 * CPB + 2);
        #2;
        rst = 1'b1;
        expq.delete();
        doneq.delete();
        dropq.delete();
        ends.delete();
        #1;
        check("arst_tx", 64'(tx), 64'd1);
        check("arst_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        check("post_rst_idle", 64'(bad), 64'd0);
        fire({16'h1234, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE});
        drain();

        check("left_bytes", 64'(expq.size()), 64'd0);
        check("left_done", 64'(doneq.size()), 64'd0);
        check("left_drop", 64'(dropq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
